bcd_hex_display: RTL and testbench
==================================

# bcd_hex_display

Multi-digit decimal display driver for the seven-segment HEX bank, the successor to the single-digit level display. Accepts a binary value on a load strobe, converts it to BCD with a sequential shift-and-add-3 (double-dabble) engine, and drives `DIGITS` active-low seven-segment outputs. Used for score, fuel and level readouts. Handshake outputs let the game FSM know when the display has updated.

## Interface
- `WIDTH`, default 8: binary input width; also the conversion length in shift cycles.
- `DIGITS`, default 3: number of decimal digits and HEX displays driven.
- `clock`  in  1: rising-edge clock.
- `Reset`  in  1: synchronous, active-low.
- `value`  in  WIDTH: unsigned binary value, sampled only on an accepted load.
- `load`  in  1: conversion request, sampled each rising edge.
- `busy`  out  1: conversion in progress; loads are ignored while high.
- `done`  out  1: one-cycle pulse when `disp`/`overflow` update.
- `overflow`  out  1: last converted value exceeded 10^DIGITS − 1.
- `disp`  out  7*DIGITS: segments; digit i in bits [7i+6:7i], digit 0 = least significant; bit 0 = a … bit 6 = g; 0 = lit.

## Operation
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE: if `load`=1, capture `value` into the shift register, clear the 4*DIGITS BCD register, load the counter with WIDTH, and go to SHIFT.
- SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift the combined {BCD, binary} left by 1. If the bit shifted out of the top nibble is 1, set the sticky overflow flag. Decrement the counter. After WIDTH shifts, go to UPDATE.
- UPDATE: register the new `disp` and `overflow`, pulse `done`, and return to IDLE.
- Segment codes (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles 10–15 cannot occur.
- Overflow: all digits show dash 0111111 and `overflow`=1. Otherwise `overflow`=0.
- `disp` holds its value between conversions. `value` changes outside an accepted load have no effect.

## Timing
- Load accepted at edge k. `busy`=1 from edge k until edge k+WIDTH+1.
- Shifts occur on edges k+1 … k+WIDTH.
- `disp`, `overflow` and `done`=1 become valid after edge k+WIDTH+1. `busy`=0 at the same edge.
- Latency from load edge to new display is WIDTH+1 cycles. Throughput is one conversion per WIDTH+2 cycles.
- `load` during `busy`, including the UPDATE cycle, is ignored and not queued.
- `load` held high continuously produces back-to-back conversions, each re-sampling `value` in IDLE.
- Reset (`Reset`=0 at an edge), including mid-conversion: abort the conversion and set state IDLE, `busy`=0, `done`=0, `overflow`=0, counter 0. `disp` shows 0 on digit 0; the other digits follow the reset-display rule in Configuration.
- `Reset` has priority over `load` on the same edge.

## Configuration
- `BCD_HEX_LZ_BLANK_EN` defined: leading-zero blanking.
  - Every zero digit above the most significant nonzero digit is driven 1111111 (dark).
  - Digit 0 always shows its value, so a value of 0 displays a single "0".
  - Reset display: digit 0 = 1000000, others dark.
  - Overflow dashes are never blanked.
- `BCD_HEX_LZ_BLANK_EN` undefined: all digits always show their decimal value, including leading zeros.
  - Reset display: every digit 1000000.

## Test plan
- Reset, then WIDTH=8, DIGITS=3, load `value`=0 → `done` after 9 cycles; `disp` digit0=1000000; digits 1–2 dark (macro on) or 1000000 (macro off); `overflow`=0.
- Load 255 → digits 2,1,0 = 0100100, 0010010, 0010010 ("255"); `busy` high exactly 9 cycles; `done` high exactly 1 cycle.
- WIDTH=10, DIGITS=3: load 1000 → all digits 0111111, `overflow`=1. Then load 999 → "999" (0010000 ×3), `overflow`=0.
- Load 42, then assert `load` with 7 on cycles 3 and 9 (busy) → only "42" is displayed; `done` pulses once. Load 7 after `busy`=0 → "7", with digit 1 dark when the macro is defined.
- Load 200, then `Reset`=0 at cycle 4 → `busy`=0, no `done`, `disp` at reset value. Load 13 after release → "13" 9 cycles later.
- `load` held high with `value` stepping 1,2,3 → `done` pulses every 10 cycles; displays 1,2,3 in sequence.

Source files
------------

// File: rtl/bcd_hex_display.sv
// rtl/bcd_hex_display.sv - binary to multi-digit seven-segment display via sequential double-dabble
// Optional feature: BCD_HEX_LZ_BLANK_EN enables leading-zero blanking.
module bcd_hex_display #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic [WIDTH-1:0]      value,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   disp
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_DARK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t              r_state, w_next;
  logic [BW-1:0]       r_bcd;
  logic [BW-1:0]       w_bcd_adj;
  logic [WIDTH-1:0]    r_bin;
  logic [CW-1:0]       r_count;
  logic                r_ovf_sticky;
  logic                r_done;
  logic                r_overflow;
  logic [7*DIGITS-1:0] r_disp;
  logic [7*DIGITS-1:0] w_disp_new;
  logic [7*DIGITS-1:0] w_disp_reset;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_DARK;
    endcase
  endfunction

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (load) w_next = SHIFT;
      SHIFT:   if (r_count == CW'(1)) w_next = UPDATE;
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_disp_reset = '0;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef BCD_HEX_LZ_BLANK_EN
      w_disp_reset[7*i +: 7] = (i == 0) ? SEG_ZERO : SEG_DARK;
`else
      w_disp_reset[7*i +: 7] = SEG_ZERO;
`endif
    end
  end

`ifdef BCD_HEX_LZ_BLANK_EN
  // Scan from the top digit; blanking stops at the first nonzero digit, and digit 0 always shows.
  always_comb begin
    logic v_lead;
    w_disp_new = '0;
    v_lead     = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (r_ovf_sticky) begin
        w_disp_new[7*i +: 7] = SEG_DASH;
      end else if (v_lead && (i != 0) && (r_bcd[4*i +: 4] == 4'd0)) begin
        w_disp_new[7*i +: 7] = SEG_DARK;
      end else begin
        v_lead               = 1'b0;
        w_disp_new[7*i +: 7] = seg7(r_bcd[4*i +: 4]);
      end
    end
  end
`else
  always_comb begin
    w_disp_new = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_disp_new[7*i +: 7] = r_ovf_sticky ? SEG_DASH : seg7(r_bcd[4*i +: 4]);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_bcd        <= '0;
      r_bin        <= '0;
      r_count      <= '0;
      r_ovf_sticky <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_disp       <= w_disp_reset;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_bin        <= value;
            r_bcd        <= '0;
            r_count      <= CW'(WIDTH);
            r_ovf_sticky <= 1'b0;
          end
        end
        SHIFT: begin
          // A carry out of the top nibble means the value needs more digits than we have.
          {r_bcd, r_bin} <= {w_bcd_adj[BW-2:0], r_bin, 1'b0};
          if (w_bcd_adj[BW-1]) r_ovf_sticky <= 1'b1;
          r_count <= r_count - CW'(1);
        end
        UPDATE: begin
          r_disp     <= w_disp_new;
          r_overflow <= r_ovf_sticky;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign overflow = r_overflow;
  assign disp     = r_disp;

endmodule

// File: tb/tb_bcd_hex_display.sv
// tb/tb_bcd_hex_display.sv - directed self-checking bench for bcd_hex_display (WIDTH=8 and WIDTH=10 instances)
module tb_bcd_hex_display;

  localparam logic [6:0] DARK = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;

  logic        clock = 1'b0;
  logic        rst8 = 1'b0, load8 = 1'b0;
  logic [7:0]  val8 = '0;
  logic        busy8, done8, ovf8;
  logic [20:0] disp8;
  logic        rst10 = 1'b0, load10 = 1'b0;
  logic [9:0]  val10 = '0;
  logic        busy10, done10, ovf10;
  logic [20:0] disp10;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  bcd_hex_display #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clock(clock), .Reset(rst8), .value(val8), .load(load8),
    .busy(busy8), .done(done8), .overflow(ovf8), .disp(disp8)
  );

  bcd_hex_display #(.WIDTH(10), .DIGITS(3)) u_dut10 (
    .clock(clock), .Reset(rst10), .value(val10), .load(load10),
    .busy(busy10), .done(done10), .overflow(ovf10), .disp(disp10)
  );

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;  1: seg = 7'b1111001;  2: seg = 7'b0100100;
      3: seg = 7'b0110000;  4: seg = 7'b0011001;  5: seg = 7'b0010010;
      6: seg = 7'b0000010;  7: seg = 7'b1111000;  8: seg = 7'b0000000;
      default: seg = 7'b0010000;
    endcase
  endfunction

  // Expected three-digit pattern for a value 0..999.
  function automatic logic [20:0] mk(input int v);
    logic [20:0] r;
    r[6:0]   = seg(v % 10);
    r[13:7]  = seg((v / 10) % 10);
    r[20:14] = seg(v / 100);
`ifdef BCD_HEX_LZ_BLANK_EN
    if (v < 100) r[20:14] = DARK;
    if (v < 10)  r[13:7]  = DARK;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Load v on one edge, then watch 15 samples after that edge; optionally retry loads of 7 while busy.
  task automatic conv8(input int v, input bit interf, output int nb, output int nd);
    load8 = 1'b1;
    val8  = 8'(v);
    tick();
    load8 = 1'b0;
    nb = 0;
    nd = 0;
    for (int j = 0; j < 15; j++) begin
      if (busy8) nb++;
      if (done8) nd++;
      if (interf) begin
        val8  = 8'd7;
        load8 = (j == 2 || j == 8);
      end
      tick();
    end
    load8 = 1'b0;
  endtask

  initial begin
    int nb, nd, last, seen;
    tick();
    tick();
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_ovf",  32'(ovf8),  32'd0);
    check("rst_disp", 32'(disp8), 32'(mk(0)));
    rst8  = 1'b1;
    rst10 = 1'b1;
    tick();

    conv8(0, 1'b0, nb, nd);
    check("v0_busy", 32'(nb), 32'd9);
    check("v0_done", 32'(nd), 32'd1);
    check("v0_disp", 32'(disp8), 32'(mk(0)));
    check("v0_ovf",  32'(ovf8),  32'd0);

    conv8(255, 1'b0, nb, nd);
    check("v255_busy", 32'(nb), 32'd9);
    check("v255_done", 32'(nd), 32'd1);
    check("v255_disp", 32'(disp8), 32'({7'b0100100, 7'b0010010, 7'b0010010}));

    conv8(42, 1'b1, nb, nd);
    check("v42_busy", 32'(nb), 32'd9);
    check("v42_done", 32'(nd), 32'd1);
    check("v42_disp", 32'(disp8), 32'(mk(42)));

    conv8(7, 1'b0, nb, nd);
    check("v7_disp", 32'(disp8), 32'(mk(7)));

    load8 = 1'b1;
    val8  = 8'd200;
    tick();
    load8 = 1'b0;
    repeat (3) tick();
    rst8 = 1'b0;
    load8 = 1'b1;
    tick();
    load8 = 1'b0;
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_done", 32'(done8), 32'd0);
    check("mid_rst_disp", 32'(disp8), 32'(mk(0)));
    rst8 = 1'b1;
    nd = 0;
    for (int j = 0; j < 12; j++) begin
      if (done8) nd++;
      tick();
    end
    check("mid_rst_nodone", 32'(nd), 32'd0);

    conv8(13, 1'b0, nb, nd);
    check("v13_done", 32'(nd), 32'd1);
    check("v13_disp", 32'(disp8), 32'(mk(13)));

    load8 = 1'b1;
    val8  = 8'd1;
    tick();
    last = 0;
    seen = 0;
    for (int j = 0; j < 30; j++) begin
      if (done8) begin
        seen++;
        check("held_disp", 32'(disp8), 32'(mk(seen)));
        if (seen > 1) check("held_gap", 32'(j - last), 32'd10);
        last = j;
        val8 = 8'(seen + 1);
        if (seen == 3) load8 = 1'b0;
      end
      tick();
    end
    load8 = 1'b0;
    check("held_count", 32'(seen), 32'd3);

    load10 = 1'b1;
    val10  = 10'd1000;
    tick();
    load10 = 1'b0;
    repeat (13) tick();
    check("v1000_ovf",  32'(ovf10),  32'd1);
    check("v1000_disp", 32'(disp10), 32'({DASH, DASH, DASH}));
    load10 = 1'b1;
    val10  = 10'd999;
    tick();
    load10 = 1'b0;
    repeat (13) tick();
    check("v999_ovf",  32'(ovf10),  32'd0);
    check("v999_disp", 32'(disp10), 32'({7'b0010000, 7'b0010000, 7'b0010000}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
